// File: rtl/acc_unit_if.sv
// ============================================================================
// acc_unit_if : op request / result bundle between control unit and acc_unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface acc_unit_if #(
  parameter int WIDTH = 8,
  parameter int SH_W  = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] q;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             busy;

  modport master (
    output in_valid, op, d, shamt,
    input  in_ready, q, flag_z, flag_n, flag_c, flag_v, busy
  );

  modport slave (
    input  in_valid, op, d, shamt,
    output in_ready, q, flag_z, flag_n, flag_c, flag_v, busy
  );
endinterface

`default_nettype wire

// File: rtl/acc_unit.sv
// ============================================================================
// acc_unit : parametrised accumulator with op-coded ALU and multi-cycle shifts
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_unit #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SH_W      = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  acc_unit_if.slave  bus
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SH_W-1:0]  cnt_q,   cnt_d;
  logic             dir_q,   dir_d;   // 1 = shift right
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic             c_q,     c_d;
  logic             v_q,     v_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // Returns {bit shifted out, shifted value}
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] a, input logic right);
    if (right) shift_step = {a[0], 1'b0, a[WIDTH-1:1]};
    else       shift_step = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    c_d     = c_q;
    v_d     = v_q;
    sum     = {1'b0, acc_q} + {1'b0, bus.d};
    diff    = {1'b0, acc_q} - {1'b0, bus.d};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.op)
            OP_NOP: ;
            OP_LOAD: begin acc_d = bus.d;        c_d = 1'b0; v_d = 1'b0; end
            OP_AND:  begin acc_d = acc_q & bus.d; c_d = 1'b0; v_d = 1'b0; end
            OP_CLR:  begin acc_d = '0;           c_d = 1'b0; v_d = 1'b0; end
            OP_ADD: begin
              acc_d = sum[WIDTH-1:0];
              c_d   = sum[WIDTH];
              v_d   = (acc_q[WIDTH-1] == bus.d[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SUB: begin
              acc_d = diff[WIDTH-1:0];
              c_d   = diff[WIDTH];
              v_d   = (acc_q[WIDTH-1] != bus.d[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SHL, OP_SHR: begin
              // Zero-length shift leaves C/V untouched
              if (bus.shamt != '0) begin
                {c_d, acc_d} = shift_step(acc_q, bus.op == OP_SHR);
                v_d          = 1'b0;
                if (bus.shamt != SH_W'(1)) begin
                  state_d = SHIFT;
                  cnt_d   = bus.shamt - SH_W'(1);
                  dir_d   = (bus.op == OP_SHR);
                end
              end
            end
            default: ;
          endcase
        end
      end
      SHIFT: begin
        {c_d, acc_d} = shift_step(acc_q, dir_q);
        v_d          = 1'b0;
        cnt_d        = cnt_q - SH_W'(1);
        if (cnt_q == SH_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      acc_q   <= RESET_VAL;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign bus.q        = acc_q;
  assign bus.flag_z   = (acc_q == '0);
  assign bus.flag_n   = acc_q[WIDTH-1];
  assign bus.flag_c   = c_q;
  assign bus.flag_v   = v_q;
  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == SHIFT);

endmodule

`default_nettype wire
